// File: rtl/pin_entry_controller_pkg.sv
// Shared definitions for the PIN entry front end: key codes, authenticator
// status encodings, FSM state encoding and the decimal digit-append helper.
package pin_entry_controller_pkg;

  // Keypad control codes (digits are 4'h0..4'h9)
  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Authenticator result encodings
  localparam logic ACCOUNT_FOUND         = 1'b1;
  localparam logic ACCOUNT_AUTHENTICATED = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_GRANTED,
    S_EJECT,
    S_LOCKED
  } state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  // Shift one decimal digit into the PIN; 16 bits hold any 4-digit value.
  function automatic logic [15:0] pin_append(input logic [15:0] pin_val,
                                             input logic [3:0]  digit);
    return (pin_val * 16'd10) + {12'd0, digit};
  endfunction

endpackage

// File: rtl/pin_entry_controller_inactivity_timer.sv
// Inactivity timer: counts cycles while enabled, restarts on request and
// flags expiry when the count reaches TIMEOUT_CYCLES-1 with no restart.
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int         W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Idle-cycle counter, held at LAST so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expire = enable && !restart && (count == LAST);

endmodule

// File: rtl/pin_entry_controller.sv
// PIN entry controller: latches the card account, collects keypad digits into
// a binary PIN, samples the authenticator, counts wrong tries and locks
// accounts. Optional build macro PIN_LOCK_CLEAR_EN adds an unlock port pair.
module pin_entry_controller
  import pin_entry_controller_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_in,
  input  logic [3:0]  card_acc_num,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
`ifdef PIN_LOCK_CLEAR_EN
  input  logic        unlock_valid,
  input  logic [3:0]  unlock_acc,
`endif
  input  logic        acc_found_stat,
  input  logic        acc_auth_stat,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        session_active,
  output logic        auth_ok,
  output logic        auth_fail,
  output logic        timeout,
  output logic        eject,
  output logic        card_retained,
  output logic [1:0]  tries_used
);

  localparam int               CNT_W        = $clog2(PIN_DIGITS + 1);
  localparam logic [CNT_W-1:0] PIN_DIGITS_C = CNT_W'(PIN_DIGITS);
  localparam logic [1:0]       MAX_TRIES_C  = 2'(MAX_TRIES);

  state_t           state;
  logic [CNT_W-1:0] digit_cnt;
  logic [15:0]      locked;
  logic             timer_expire;
  logic             wrong_pin;
  logic             lock_set;
  logic [1:0]       tries_next;

  inactivity_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart ((state != S_ENTRY) || key_valid),
    .enable  (state == S_ENTRY),
    .expire  (timer_expire)
  );

  assign tries_next = tries_used + 2'd1;
  assign wrong_pin  = card_in && (state == S_CHECK) &&
                      (acc_found_stat == ACCOUNT_FOUND) &&
                      (acc_auth_stat != ACCOUNT_AUTHENTICATED);
  assign lock_set   = wrong_pin && (tries_next == MAX_TRIES_C);

  // Per-account lock table; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the lock table is a small flop array that must come up cleared, so it
    // sits under the async reset like any other state rather than as an unreset RAM.
    if (!rst_n) begin
      locked <= '0;
    end else begin
`ifdef PIN_LOCK_CLEAR_EN
      if (unlock_valid) locked[unlock_acc] <= 1'b0;
`endif
      if (lock_set) locked[acc_num] <= 1'b1;
    end
  end

  // Session FSM with registered level outputs and one-cycle result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all FSM state and outputs use non-blocking assignment so every
    // branch reads the pre-edge values and later pulse defaults can be overridden.
    if (!rst_n) begin
      state          <= S_IDLE;
      acc_num        <= '0;
      pin            <= '0;
      digit_cnt      <= '0;
      tries_used     <= '0;
      session_active <= 1'b0;
      auth_ok        <= 1'b0;
      auth_fail      <= 1'b0;
      timeout        <= 1'b0;
      eject          <= 1'b0;
      card_retained  <= 1'b0;
    end else begin
      auth_ok   <= 1'b0;
      auth_fail <= 1'b0;
      timeout   <= 1'b0;
      if (!card_in) begin
        state          <= S_IDLE;
        pin            <= '0;
        digit_cnt      <= '0;
        session_active <= 1'b0;
        eject          <= 1'b0;
        card_retained  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            acc_num    <= card_acc_num;
            pin        <= '0;
            digit_cnt  <= '0;
            tries_used <= '0;
            if (locked[card_acc_num]) begin
              state         <= S_LOCKED;
              card_retained <= 1'b1;
            end else begin
              state <= S_ENTRY;
            end
          end
          S_ENTRY: begin
            if (key_valid) begin
              if (is_digit(key_code)) begin
                if (digit_cnt < PIN_DIGITS_C) begin
                  pin       <= pin_append(pin, key_code);
                  digit_cnt <= digit_cnt + CNT_W'(1);
                end
              end else begin
                case (key_code)
                  KEY_CLEAR: begin
                    pin       <= '0;
                    digit_cnt <= '0;
                  end
                  KEY_ENTER: if (digit_cnt == PIN_DIGITS_C) state <= S_CHECK;
                  KEY_CANCEL: begin
                    state <= S_EJECT;
                    eject <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end else if (timer_expire) begin
              timeout <= 1'b1;
              state   <= S_EJECT;
              eject   <= 1'b1;
            end
          end
          S_CHECK: begin
            if (acc_found_stat != ACCOUNT_FOUND) begin
              auth_fail <= 1'b1;
              state     <= S_EJECT;
              eject     <= 1'b1;
            end else if (acc_auth_stat == ACCOUNT_AUTHENTICATED) begin
              auth_ok        <= 1'b1;
              state          <= S_GRANTED;
              session_active <= 1'b1;
            end else begin
              auth_fail  <= 1'b1;
              tries_used <= tries_next;
              if (lock_set) begin
                state         <= S_LOCKED;
                card_retained <= 1'b1;
              end else begin
                pin       <= '0;
                digit_cnt <= '0;
                state     <= S_ENTRY;
              end
            end
          end
          default: ; // GRANTED, EJECT, LOCKED wait for card removal
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pin_entry_controller.sv
// Self-checking bench for pin_entry_controller with a behavioural authenticator
// (acc 3 / PIN 1234, acc 7 / PIN 42) and an auth result scoreboard.
module tb_pin_entry_controller;
  import pin_entry_controller_pkg::*;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        card_in = 1'b0;
  logic [3:0]  card_acc_num = '0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        acc_found_stat, acc_auth_stat;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        session_active, auth_ok, auth_fail, timeout, eject, card_retained;
  logic [1:0]  tries_used;
`ifdef PIN_LOCK_CLEAR_EN
  logic        unlock_valid = 1'b0;
  logic [3:0]  unlock_acc = '0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic ok;
    int   cyc;
  } exp_t;
  exp_t sb_q[$];

  pin_entry_controller #(.PIN_DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .card_in        (card_in),
    .card_acc_num   (card_acc_num),
    .key_valid      (key_valid),
    .key_code       (key_code),
`ifdef PIN_LOCK_CLEAR_EN
    .unlock_valid   (unlock_valid),
    .unlock_acc     (unlock_acc),
`endif
    .acc_found_stat (acc_found_stat),
    .acc_auth_stat  (acc_auth_stat),
    .acc_num        (acc_num),
    .pin            (pin),
    .session_active (session_active),
    .auth_ok        (auth_ok),
    .auth_fail      (auth_fail),
    .timeout        (timeout),
    .eject          (eject),
    .card_retained  (card_retained),
    .tries_used     (tries_used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural authenticator
  always_comb begin
    acc_found_stat = (acc_num == 4'd3) || (acc_num == 4'd7);
    acc_auth_stat  = ((acc_num == 4'd3) && (pin == 16'd1234)) ||
                     ((acc_num == 4'd7) && (pin == 16'd42));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: compare every result pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (auth_ok || auth_fail)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", {30'd0, auth_ok, auth_fail}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("auth_kind", {30'd0, auth_ok, auth_fail}, e.ok ? 32'd2 : 32'd1);
        check("auth_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
  endtask

  task automatic press_pin(input logic [3:0] d0, d1, d2, d3);
    press(d0); press(d1); press(d2); press(d3);
  endtask

  task automatic press_enter(input logic exp_ok);
    exp_t e;
    e.ok  = exp_ok;
    e.cyc = cyc + 2;
    sb_q.push_back(e);
    press(KEY_ENTER);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1);
    check("sb_drain", sb_q.size(), 0);
  endtask

  task automatic insert(input logic [3:0] acc);
    card_acc_num = acc;
    card_in      = 1'b1;
    tick(1);
  endtask

  task automatic remove();
    card_in = 1'b0;
    tick(1);
  endtask

  function automatic logic [31:0] all_outs();
    return {4'd0, acc_num, pin, session_active, auth_ok, auth_fail, timeout,
            eject, card_retained, tries_used};
  endfunction

  task automatic lock_account_3();
    insert(4'd3);
    for (int t = 0; t < 3; t++) begin
      press_pin(4'd9, 4'd9, 4'd9, 4'd9);
      press_enter(1'b0);
      tick(2);
      wait_sb();
      check("lock_tries_used", tries_used, t + 1);
    end
    check("lock_retained", card_retained, 1);
  endtask

  initial begin
    int key_cyc;
    int seen;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int key_cyc;
    int seen;

    // Reset state
    tick(3);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    tick(1);

    // Correct PIN on account 3
    insert(4'd3);
    check("acc_latched", acc_num, 3);
    press_pin(4'd1, 4'd2, 4'd3, 4'd4);
    check("pin_1234", pin, 1234);
    press_enter(1'b1);
    tick(2);
    wait_sb();
    check("granted_active", session_active, 1);
    remove();
    check("granted_released", session_active, 0);

    // Three wrong PINs lock account 3, reinsertion goes straight to LOCKED
    lock_account_3();
    remove();
    check("retain_cleared", card_retained, 0);
    insert(4'd3);
    check("relock_direct", card_retained, 1);
    remove();

    // Account 7 with CLEAR and an ignored fifth digit
    insert(4'd7);
    press(4'd0); press(4'd0); press(4'd4); press(KEY_CLEAR);
    check("pin_cleared", pin, 0);
    press(4'd0); press(4'd0); press(4'd4); press(4'd2); press(4'd5);
    check("pin_42", pin, 42);
    press_enter(1'b1);
    tick(2);
    wait_sb();
    check("acc7_active", session_active, 1);
    remove();

    // Unknown account 5
    insert(4'd5);
    press_pin(4'd1, 4'd1, 4'd1, 4'd1);
    press_enter(1'b0);
    tick(2);
    wait_sb();
    check("absent_eject", eject, 1);
    check("absent_tries", tries_used, 0);

    // Asynchronous reset mid-session clears everything at once
    #2 rst_n = 1'b0;
    #1 check("async_reset", all_outs(), 0);
    card_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Inactivity timeout after a single key (lock on 3 cleared by reset)
    insert(4'd3);
    check("unlocked_after_reset", card_retained, 0);
    key_cyc = cyc;
    press(4'd1);
    seen = 0;
    for (int i = 0; i < TIMEOUT + 50; i++) begin
      @(negedge clk);
      if (timeout) begin
        seen = cyc;
        break;
      end
    end
    check("timeout_latency", seen - key_cyc, TIMEOUT + 1);
    check("timeout_eject", eject, 1);
    @(negedge clk);
    check("timeout_one_cycle", timeout, 0);
    #6;
    remove();

    // Short ENTER ignored, CANCEL ejects
    insert(4'd7);
    press(4'd4); press(4'd2); press(KEY_ENTER);
    tick(3);
    check("short_enter_pin", pin, 42);
    check("short_enter_no_eject", eject, 0);
    press(KEY_CANCEL);
    check("cancel_eject", eject, 1);
    remove();

    // Card removed mid-ENTRY
    insert(4'd7);
    press(4'd1); press(4'd2);
    check("pin_12", pin, 12);
    remove();
    check("drop_pin_cleared", pin, 0);

    // Card removed during CHECK: no pulse, no try counted
    insert(4'd7);
    press_pin(4'd9, 4'd9, 4'd9, 4'd9);
    press(KEY_ENTER);
    card_in = 1'b0;
    tick(3);
    check("drop_check_tries", tries_used, 0);
    check("drop_check_pin", pin, 0);

`ifdef PIN_LOCK_CLEAR_EN
    // Unlock an account and log in again
    lock_account_3();
    remove();
    unlock_acc   = 4'd3;
    unlock_valid = 1'b1;
    tick(1);
    unlock_valid = 1'b0;
    insert(4'd3);
    check("unlock_entry", card_retained, 0);
    press_pin(4'd1, 4'd2, 4'd3, 4'd4);
    press_enter(1'b1);
    tick(2);
    wait_sb();
    check("unlock_active", session_active, 1);
    remove();
`endif

    check("sb_final_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
